writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_if.sv | 29 ++
 rtl/writeback_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/writeback_unit_if.sv
// ---------------------------------------------------------------------------
// writeback_unit_if
// Result channel between a producer (ALU or load path) and writeback_unit.
//   res_valid : producer offers a completed result
//   res_rd    : destination register of the offered result
//   res_data  : result value
//   res_ready : writeback_unit accepts the offered result this cycle
// master = producer side, slave = writeback_unit side.
// ---------------------------------------------------------------------------
interface writeback_unit_if;
    logic        res_valid;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        res_ready;

    modport master (
        output res_valid,
        output res_rd,
        output res_data,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_rd,
        input  res_data,
        output res_ready
    );
endinterface

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Buffers completed results in a small FIFO and drains one entry per cycle
// into the register-file write port. It also keeps a per-register
// pending-write scoreboard and a sticky protocol-violation flag.
//
// Ports
//   CLK         : clock, all state updates on the rising edge
//   RESET       : synchronous, active-high reset
//   issue_valid : decode issues an instruction that writes issue_rd
//   issue_rd    : destination register of the issued instruction
//   res_if      : result channel (valid/rd/data in, ready out)
//   RegWrite    : register-file write enable (registered)
//   WriteReg    : register-file write address (registered)
//   WriteData   : register-file write data (registered)
//   busy        : pending-write scoreboard, bit r set while r awaits its write
//   err         : sticky protocol-violation flag
// ---------------------------------------------------------------------------
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    writeback_unit_if.slave      res_if,
    output logic                 RegWrite,
    output logic [4:0]           WriteReg,
    output logic [31:0]          WriteData,
    output logic [31:0]          busy,
    output logic                 err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Each FIFO entry packs {rd, data}.
    logic [36:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             r_reg_write;
    logic [4:0]       r_write_reg;
    logic [31:0]      r_write_data;
    logic [31:0]      r_busy;
    logic             r_err;

    logic             w_full;
    logic             w_ready;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [36:0]      w_head;
    logic [4:0]       w_head_rd;
    logic [CNT_W-1:0] w_count_next;
    logic [31:0]      w_busy_next;
    logic             w_issue_viol;
    logic             w_res_viol;

    // Ready depends only on stored occupancy, so a pop in the same cycle
    // never re-opens a full FIFO and there is no valid->ready path.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_ready   = ~w_full;
    assign w_accept  = res_if.res_valid & w_ready;
    // Writes to r0 are architecturally meaningless: accept but drop them.
    assign w_push    = w_accept & (res_if.res_rd != 5'd0);
    assign w_pop     = (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_rd = w_head[36:32];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Scoreboard: a new issue wins over the clear from a same-edge pop,
    // because the new instruction's write is still outstanding.
    assign w_busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic w_set;
            logic w_clr;
            assign w_set = issue_valid & (issue_rd == 5'(gi));
            assign w_clr = w_pop & (w_head_rd == 5'(gi));
            assign w_busy_next[gi] = w_set | (r_busy[gi] & ~w_clr);
        end
    endgenerate

    // Violations are judged against the scoreboard as it stood before this edge.
    assign w_issue_viol = issue_valid & (issue_rd != 5'd0) & r_busy[issue_rd];
    assign w_res_viol   = w_accept & (res_if.res_rd != 5'd0) & ~r_busy[res_if.res_rd];

    // Storage array kept free of reset so it can map onto RAM resources;
    // stale contents are unreachable once the pointers are reset.
    always_ff @(posedge CLK) begin
        if (w_push && !RESET) begin
            r_mem[r_wr_ptr] <= {res_if.res_rd, res_if.res_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
            r_busy       <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_write_reg  <= w_head_rd;
                r_write_data <= w_head[31:0];
            end
            r_reg_write <= w_pop;
            r_count     <= w_count_next;
            r_busy      <= w_busy_next;
            if (w_issue_viol || w_res_viol) begin
                r_err <= 1'b1;
            end
        end
    end

    assign res_if.res_ready = w_ready;
    assign RegWrite         = r_reg_write;
    assign WriteReg         = r_write_reg;
    assign WriteData        = r_write_data;
    assign busy             = r_busy;
    assign err              = r_err;
endmodule
